// File: rtl/reset_sequencer.sv
// Reset sequencer: steps through the full, instruction, IO and data reset phases for a
// software reset request, then returns a single response pulse to system control.
module reset_sequencer #(
    parameter int FULL_RESET_CYCLES = 16,
    parameter int ACK_TIMEOUT       = 255
) (
    input  logic       clk,
    input  logic       clk_en,
    input  logic       sync_rst,
    input  logic       SoftwareResetIn,
    input  logic [3:0] ResetVectorIn,
    input  logic       IOResetAck,
    input  logic       DataResetAck,
    output logic       FullResetOut,
    output logic       InstFlushOut,
    output logic       IOResetReq,
    output logic       DataResetReq,
    output logic       ResetResponseOut,
    output logic       Busy,
    output logic [1:0] TimeoutStatus
);

    localparam int MaxCount   = (FULL_RESET_CYCLES > ACK_TIMEOUT) ? FULL_RESET_CYCLES : ACK_TIMEOUT;
    localparam int CountWidth = $clog2(MaxCount + 1);

    localparam logic [CountWidth-1:0] FullLoad = CountWidth'(FULL_RESET_CYCLES - 1);
    localparam logic [CountWidth-1:0] AckLoad  = CountWidth'(ACK_TIMEOUT - 1);
    localparam logic [CountWidth-1:0] CountOne = CountWidth'(1);

    typedef enum logic [2:0] {
        IDLE,
        FULL,
        INST,
        IO,
        DATA,
        RESP
    } StateT;

    StateT                 state;
    StateT                 nextState;
    logic [CountWidth-1:0] count;
    logic [CountWidth-1:0] nextCount;
    logic [3:0]            vector;
    logic [3:0]            nextVector;
    logic [1:0]            timeoutReg;
    logic [1:0]            nextTimeout;

    // Vector bits are {Full, Inst, IO, Data}; the caller masks off phases already done.
    function automatic StateT firstPhase(input logic [3:0] pending);
        if (pending[3])      return FULL;
        else if (pending[2]) return INST;
        else if (pending[1]) return IO;
        else if (pending[0]) return DATA;
        else                 return RESP;
    endfunction

    function automatic logic [CountWidth-1:0] entryLoad(input StateT s);
        case (s)
            FULL:     return FullLoad;
            IO, DATA: return AckLoad;
            default:  return '0;
        endcase
    endfunction

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned and no latch is inferred.
        nextState   = state;
        nextCount   = count;
        nextVector  = vector;
        nextTimeout = timeoutReg;

        case (state)
            IDLE: begin
                if (SoftwareResetIn) begin
                    nextVector  = ResetVectorIn | {4{ResetVectorIn[3]}};
                    nextTimeout = '0;
                    nextState   = firstPhase(nextVector);
                end
            end
            FULL: begin
                if (count == '0) nextState = firstPhase(vector & 4'b0111);
                else             nextCount = count - CountOne;
            end
            INST: nextState = firstPhase(vector & 4'b0011);
            IO: begin
                // An ack on the last timeout cycle wins over the timeout.
                if (IOResetAck) begin
                    nextState = firstPhase(vector & 4'b0001);
                end else if (count == '0) begin
                    nextTimeout[0] = 1'b1;
                    nextState      = firstPhase(vector & 4'b0001);
                end else begin
                    nextCount = count - CountOne;
                end
            end
            DATA: begin
                if (DataResetAck) begin
                    nextState = RESP;
                end else if (count == '0) begin
                    nextTimeout[1] = 1'b1;
                    nextState      = RESP;
                end else begin
                    nextCount = count - CountOne;
                end
            end
            RESP:    nextState = IDLE;
            default: nextState = IDLE;
        endcase

        // Every phase entry reloads the counter, so it never wraps.
        if (nextState != state) nextCount = entryLoad(nextState);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
        if (sync_rst) begin
            state            <= IDLE;
            count            <= '0;
            vector           <= '0;
            timeoutReg       <= '0;
            FullResetOut     <= 1'b0;
            InstFlushOut     <= 1'b0;
            IOResetReq       <= 1'b0;
            DataResetReq     <= 1'b0;
            ResetResponseOut <= 1'b0;
            Busy             <= 1'b0;
        end else if (clk_en) begin
            state            <= nextState;
            count            <= nextCount;
            vector           <= nextVector;
            timeoutReg       <= nextTimeout;
            // Outputs are registered copies of the state decode, so they hold with clk_en low.
            FullResetOut     <= (nextState == FULL);
            InstFlushOut     <= (nextState == INST);
            IOResetReq       <= (nextState == IO);
            DataResetReq     <= (nextState == DATA);
            ResetResponseOut <= (nextState == RESP);
            Busy             <= (nextState != IDLE);
        end
    end

    assign TimeoutStatus = timeoutReg;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: one default instance and one with ACK_TIMEOUT=4.
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       clk_en;
    logic       sync_rst;
    logic       swReqA;
    logic       swReqT;
    logic [3:0] resetVector;
    logic       ioAck;
    logic       dataAck;

    logic       fullA, flushA, ioReqA, dataReqA, respA, busyA;
    logic [1:0] tsA;
    logic       fullT, flushT, ioReqT, dataReqT, respT, busyT;
    logic [1:0] tsT;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    reset_sequencer dutA (
        .clk(clk), .clk_en(clk_en), .sync_rst(sync_rst),
        .SoftwareResetIn(swReqA), .ResetVectorIn(resetVector),
        .IOResetAck(ioAck), .DataResetAck(dataAck),
        .FullResetOut(fullA), .InstFlushOut(flushA), .IOResetReq(ioReqA),
        .DataResetReq(dataReqA), .ResetResponseOut(respA), .Busy(busyA),
        .TimeoutStatus(tsA)
    );

    reset_sequencer #(.ACK_TIMEOUT(4)) dutT (
        .clk(clk), .clk_en(clk_en), .sync_rst(sync_rst),
        .SoftwareResetIn(swReqT), .ResetVectorIn(resetVector),
        .IOResetAck(ioAck), .DataResetAck(dataAck),
        .FullResetOut(fullT), .InstFlushOut(flushT), .IOResetReq(ioReqT),
        .DataResetReq(dataReqT), .ResetResponseOut(respT), .Busy(busyT),
        .TimeoutStatus(tsT)
    );

    // Packed view: {full, flush, ioReq, dataReq, resp, busy, timeout[1:0]}
    function automatic logic [7:0] obsA();
        return {fullA, flushA, ioReqA, dataReqA, respA, busyA, tsA};
    endfunction

    function automatic logic [7:0] obsT();
        return {fullT, flushT, ioReqT, dataReqT, respT, busyT, tsT};
    endfunction

    function automatic logic [7:0] expV(input bit full, input bit flush, input bit io,
                                        input bit data, input bit resp, input bit busy,
                                        input logic [1:0] ts);
        return {full, flush, io, data, resp, busy, ts};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] exp;
        sync_rst = 1'b1; clk_en = 1'b1; swReqA = 1'b0; swReqT = 1'b0;
        resetVector = 4'b0000; ioAck = 1'b0; dataAck = 1'b0;
        tick(); tick();
        exp = 8'h00;
        if (obsA() !== exp) begin
            $display("FAIL reset_a got=%b exp=%b", obsA(), exp); miscompares++;
        end
        vectors++;
        if (obsT() !== exp) begin
            $display("FAIL reset_t got=%b exp=%b", obsT(), exp); miscompares++;
        end
        vectors++;

        sync_rst = 1'b0; swReqA = 1'b1; resetVector = 4'b1000;
        tick();
        swReqA = 1'b0;
        exp = expV(1, 0, 0, 0, 0, 1, 2'b00);
        if (obsA() !== exp) begin
            $display("FAIL reset_full_start got=%b exp=%b", obsA(), exp); miscompares++;
        end
        vectors++;
        repeat (4) tick();
        sync_rst = 1'b1;
        tick();
        sync_rst = 1'b0;
        if (obsA() !== 8'h00) begin
            $display("FAIL reset_mid_full got=%b exp=%b", obsA(), 8'h00); miscompares++;
        end
        vectors++;
        for (int c = 1; c <= 25; c++) begin
            tick();
            if (obsA() !== 8'h00) begin
                $display("FAIL reset_aborted c=%0d got=%b exp=%b", c, obsA(), 8'h00); miscompares++;
            end
            vectors++;
        end

        swReqA = 1'b1; resetVector = 4'b0100;
        tick();
        swReqA = 1'b0;
        exp = expV(0, 1, 0, 0, 0, 1, 2'b00);
        if (obsA() !== exp) begin
            $display("FAIL reset_inst_flush got=%b exp=%b", obsA(), exp); miscompares++;
        end
        vectors++;
        tick();
        exp = expV(0, 0, 0, 0, 1, 1, 2'b00);
        if (obsA() !== exp) begin
            $display("FAIL reset_inst_resp got=%b exp=%b", obsA(), exp); miscompares++;
        end
        vectors++;
        tick();
        if (obsA() !== 8'h00) begin
            $display("FAIL reset_inst_idle got=%b exp=%b", obsA(), 8'h00); miscompares++;
        end
        vectors++;
    endtask

    task automatic test_empty();
        logic [7:0] exp;
        swReqA = 1'b1; resetVector = 4'b0000;
        for (int c = 1; c <= 3; c++) begin
            tick();
            swReqA = 1'b0;
            exp = expV(0, 0, 0, 0, c == 1, c == 1, 2'b00);
            if (obsA() !== exp) begin
                $display("FAIL empty c=%0d got=%b exp=%b", c, obsA(), exp); miscompares++;
            end
            vectors++;
        end
    endtask

    task automatic test_full();
        logic [7:0] exp;
        swReqA = 1'b1; resetVector = 4'b1000;
        for (int c = 1; c <= 25; c++) begin
            tick();
            swReqA  = 1'b0;
            ioAck   = (c == 21);
            dataAck = (c == 22);
            exp = expV(c >= 1 && c <= 16, c == 17, c >= 18 && c <= 21, c == 22,
                       c == 23, c >= 1 && c <= 23, 2'b00);
            if (obsA() !== exp) begin
                $display("FAIL full c=%0d got=%b exp=%b", c, obsA(), exp); miscompares++;
            end
            vectors++;
        end
        ioAck = 1'b0; dataAck = 1'b0;
    endtask

    task automatic test_timeout();
        logic [7:0] exp;
        swReqT = 1'b1; resetVector = 4'b0011;
        for (int c = 1; c <= 10; c++) begin
            tick();
            swReqT  = 1'b0;
            dataAck = (c == 6);
            exp = expV(0, 0, c >= 1 && c <= 4, c >= 5 && c <= 6, c == 7,
                       c >= 1 && c <= 7, (c >= 5) ? 2'b01 : 2'b00);
            if (obsT() !== exp) begin
                $display("FAIL timeout c=%0d got=%b exp=%b", c, obsT(), exp); miscompares++;
            end
            vectors++;
        end
        dataAck = 1'b0;
        swReqT = 1'b1; resetVector = 4'b0000;
        tick();
        swReqT = 1'b0;
        exp = expV(0, 0, 0, 0, 1, 1, 2'b00);
        if (obsT() !== exp) begin
            $display("FAIL timeout_clear got=%b exp=%b", obsT(), exp); miscompares++;
        end
        vectors++;
        tick();
    endtask

    task automatic test_clk_en_gap();
        logic [7:0] exp;
        swReqA = 1'b1; resetVector = 4'b0100;
        for (int c = 1; c <= 9; c++) begin
            tick();
            swReqA = 1'b0;
            clk_en = !(c inside {1, 2, 3, 5, 6});
            exp = expV(0, c >= 1 && c <= 4, 0, 0, c >= 5 && c <= 7, c >= 1 && c <= 7, 2'b00);
            if (obsA() !== exp) begin
                $display("FAIL clk_en_gap c=%0d got=%b exp=%b", c, obsA(), exp); miscompares++;
            end
            vectors++;
        end
        clk_en = 1'b1;
    endtask

    task automatic test_ignored();
        logic [7:0] exp;
        swReqA = 1'b1; resetVector = 4'b0011;
        for (int c = 1; c <= 8; c++) begin
            tick();
            swReqA      = (c == 2);
            resetVector = (c == 2) ? 4'b1000 : 4'b0011;
            ioAck       = (c == 3);
            dataAck     = (c == 2) || (c == 5);
            exp = expV(0, 0, c >= 1 && c <= 3, c >= 4 && c <= 5, c == 6,
                       c >= 1 && c <= 6, 2'b00);
            if (obsA() !== exp) begin
                $display("FAIL ignored c=%0d got=%b exp=%b", c, obsA(), exp); miscompares++;
            end
            vectors++;
        end
        swReqA = 1'b0; ioAck = 1'b0; dataAck = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp;
        swReqA = 1'b1; resetVector = 4'b0000;
        for (int c = 1; c <= 5; c++) begin
            tick();
            swReqA      = (c <= 2);
            resetVector = 4'b0100;
            exp = expV(0, c == 3, 0, 0, c == 1 || c == 4, c == 1 || c == 3 || c == 4, 2'b00);
            if (obsA() !== exp) begin
                $display("FAIL back_to_back c=%0d got=%b exp=%b", c, obsA(), exp); miscompares++;
            end
            vectors++;
        end
        swReqA = 1'b0;
    endtask

    initial begin
        test_reset();
        test_empty();
        test_full();
        test_timeout();
        test_clk_en_gap();
        test_ignored();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
